dff_bank_sched: RTL and testbench

Controller that shares one W-bit bank of edge-triggered D flip-flops with active-low preset/clear between two requesters. It arbitrates requests, sequences LOAD/SET/CLEAR operations onto the bank's data, clock-enable, preset and clear lines, and enforces a recovery gap after every preset or clear pulse. It sits between the requesting control logic and the flip-flop bank. All outputs to the bank are registered and glitch-free.

---
 rtl/dff_bank_sched.sv | 143 ++++++++++++++
 tb/tb_dff_bank_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_sched.sv
//------------------------------------------------------------------------------
// Module   : dff_bank_sched
// Purpose  : Shares one W-bit D flip-flop bank (active-low preset/clear)
//            between two requesters. Arbitrates, drives one LOAD/SET/CLEAR
//            strobe per grant and holds off new grants for RECOVER_CYC
//            cycles after every preset or clear pulse. All bank-facing
//            outputs come straight from flops.
// Options  : DFF_BANK_SCHED_RR_EN - defined: round-robin arbitration when
//            both request; undefined: req0 has fixed priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dff_bank_sched #(
   parameter int W           = 8,
   parameter int RECOVER_CYC = 1
) (
   input  logic         CLK,
   input  logic         RST_b,
   input  logic         req0,
   input  logic         req1,
   input  logic [1:0]   op0,
   input  logic [1:0]   op1,
   input  logic [W-1:0] data0,
   input  logic [W-1:0] data1,
   output logic         ack0,
   output logic         ack1,
   output logic         busy,
   output logic         last_grant,
   output logic [W-1:0] reg_d,
   output logic         reg_ce,
   output logic         reg_pre_b,
   output logic         reg_clr_b
);

   // Counter only needs to hold RECOVER_CYC-1 down to zero.
   localparam int               CNT_W    = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RECOVER_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SET   = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC    = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       lat_op;
   logic [CNT_W-1:0] cnt;

   logic             win;
   logic [1:0]       win_op;
   logic [W-1:0]     win_data;

   // Winner selection; only consumed in IDLE, never drives an output directly.
   always_comb begin
      win = 1'b0;
`ifdef DFF_BANK_SCHED_RR_EN
      if (req0 && req1) begin
         win = ~last_grant;
      end else begin
         win = ~req0;
      end
`else
      win = ~req0;
`endif
      win_op   = win ? op1   : op0;
      win_data = win ? data1 : data0;
   end

   // Sequencer: strobes and acks are pre-computed at the grant edge so they
   // appear glitch-free from flops for exactly the EXEC cycle.
   always_ff @(posedge CLK or negedge RST_b) begin
      if (!RST_b) begin
         state      <= ST_IDLE;
         lat_op     <= OP_LOAD;
         cnt        <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         busy       <= 1'b0;
         last_grant <= 1'b1;
         reg_d      <= '0;
         reg_ce     <= 1'b0;
         reg_pre_b  <= 1'b1;
         reg_clr_b  <= 1'b1;
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         reg_ce    <= 1'b0;
         reg_pre_b <= 1'b1;
         reg_clr_b <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (req0 || req1) begin
                  state      <= ST_EXEC;
                  busy       <= 1'b1;
                  last_grant <= win;
                  lat_op     <= win_op;
                  ack0       <= ~win;
                  ack1       <= win;
                  case (win_op)
                     OP_LOAD: begin
                        reg_ce <= 1'b1;
                        reg_d  <= win_data;
                     end
                     OP_SET:   reg_pre_b <= 1'b0;
                     OP_CLEAR: reg_clr_b <= 1'b0;
                     default:  ; // reserved op: acked, no strobe
                  endcase
               end
            end
            ST_EXEC: begin
               if (lat_op == OP_SET || lat_op == OP_CLEAR) begin
                  state <= ST_RECOVER;
                  cnt   <= CNT_INIT;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_RECOVER: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dff_bank_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_dff_bank_sched
// Purpose  : Self-checking bench for dff_bank_sched. A schedule-based model
//            (queue of expected per-cycle output records) is compared against
//            the DUT every cycle; directed literal checks pin the model.
// Options  : honours DFF_BANK_SCHED_RR_EN for the arbitration expectation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dff_bank_sched;

   localparam int W  = 8;
   localparam int RC = 2;

   logic         CLK   = 1'b0;
   logic         RST_b = 1'b1;
   logic         req0  = 1'b0;
   logic         req1  = 1'b0;
   logic [1:0]   op0   = 2'b00;
   logic [1:0]   op1   = 2'b00;
   logic [W-1:0] data0 = '0;
   logic [W-1:0] data1 = '0;
   logic         ack0, ack1, busy, last_grant;
   logic [W-1:0] reg_d;
   logic         reg_ce, reg_pre_b, reg_clr_b;

   dff_bank_sched #(.W(W), .RECOVER_CYC(RC)) dut (
      .CLK        (CLK),
      .RST_b      (RST_b),
      .req0       (req0),
      .req1       (req1),
      .op0        (op0),
      .op1        (op1),
      .data0      (data0),
      .data1      (data1),
      .ack0       (ack0),
      .ack1       (ack1),
      .busy       (busy),
      .last_grant (last_grant),
      .reg_d      (reg_d),
      .reg_ce     (reg_ce),
      .reg_pre_b  (reg_pre_b),
      .reg_clr_b  (reg_clr_b)
   );

   always #5 CLK = ~CLK;

   int   nchk   = 0;
   int   nerr   = 0;
   logic cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs of one clock cycle.
   typedef struct packed {
      logic a0, a1, ce, pre_b, clr_b, busy;
   } rec_t;

   localparam rec_t IDLE_R = '{a0:1'b0, a1:1'b0, ce:1'b0, pre_b:1'b1, clr_b:1'b1, busy:1'b0};

   rec_t         sched[$];
   rec_t         cur  = IDLE_R;
   logic [W-1:0] m_d  = '0;
   logic         m_lg = 1'b1;

   // Model: when the cycle just ending was idle and someone requests, queue
   // one EXEC record plus RC busy records for SET/CLEAR.
   initial begin
      rec_t e;
      logic w;
      logic [1:0] op;
      forever begin
         @(posedge CLK or negedge RST_b);
         if (!RST_b) begin
            sched.delete();
            cur  = IDLE_R;
            m_d  = '0;
            m_lg = 1'b1;
         end else begin
            if (!cur.busy && (req0 || req1)) begin
`ifdef DFF_BANK_SCHED_RR_EN
               w = (req0 && req1) ? !m_lg : !req0;
`else
               w = req0 ? 1'b0 : 1'b1;
`endif
               op   = w ? op1 : op0;
               m_lg = w;
               e    = IDLE_R;
               e.busy = 1'b1;
               if (w) e.a1 = 1'b1; else e.a0 = 1'b1;
               if (op == 2'd0) begin
                  e.ce = 1'b1;
                  m_d  = w ? data1 : data0;
               end
               if (op == 2'd1) e.pre_b = 1'b0;
               if (op == 2'd2) e.clr_b = 1'b0;
               sched.push_back(e);
               if (op == 2'd1 || op == 2'd2) begin
                  e = IDLE_R;
                  e.busy = 1'b1;
                  repeat (RC) sched.push_back(e);
               end
            end
            cur = (sched.size() > 0) ? sched.pop_front() : IDLE_R;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (cmp_en) begin
            chk("ack0",       ack0,       cur.a0);
            chk("ack1",       ack1,       cur.a1);
            chk("reg_ce",     reg_ce,     cur.ce);
            chk("reg_pre_b",  reg_pre_b,  cur.pre_b);
            chk("reg_clr_b",  reg_clr_b,  cur.clr_b);
            chk("busy",       busy,       cur.busy);
            chk("reg_d",      reg_d,      m_d);
            chk("last_grant", last_grant, m_lg);
            chk("pre_clr_excl", (!reg_pre_b && !reg_clr_b), 0);
            chk("ce_strobe_excl", (reg_ce && (!reg_pre_b || !reg_clr_b)), 0);
         end
      end
   end

   task automatic in_cycle();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      #1 RST_b = 1'b0;
      #1;
      cmp_en = 1'b1;
      chk("rst_busy",  busy,       0);
      chk("rst_lg",    last_grant, 1);
      chk("rst_reg_d", reg_d,      0);
      chk("rst_pre_b", reg_pre_b,  1);
      chk("rst_clr_b", reg_clr_b,  1);
      chk("rst_ce",    reg_ce,     0);
      chk("rst_ack",   {ack0, ack1}, 0);
      repeat (2) @(negedge CLK);
      RST_b = 1'b1;

      // LOAD 0xA5 from req0
      @(negedge CLK);
      req0 = 1'b1; op0 = 2'd0; data0 = 8'hA5;
      in_cycle();
      chk("load_ack0",  ack0,   1);
      chk("load_ce",    reg_ce, 1);
      chk("load_reg_d", reg_d,  8'hA5);
      @(negedge CLK);
      req0 = 1'b0;
      in_cycle();
      chk("load_busy_low", busy, 0);

      // SET from req1, RECOVER_CYC=2
      @(negedge CLK);
      req1 = 1'b1; op1 = 2'd1;
      in_cycle();
      chk("set_pre_b", reg_pre_b, 0);
      chk("set_ack1",  ack1,      1);
      @(negedge CLK);
      req1 = 1'b0;
      in_cycle();
      chk("set_rec1_busy", busy, 1);
      chk("set_rec1_pre",  reg_pre_b, 1);
      in_cycle();
      chk("set_rec2_busy", busy, 1);
      in_cycle();
      chk("set_idle_busy", busy, 0);

      // CLEAR from req0 with LOAD 0xFF from req1 pending behind it
      @(negedge CLK);
      req0 = 1'b1; op0 = 2'd2;
      in_cycle();
      chk("clr_clr_b", reg_clr_b, 0);
      @(negedge CLK);
      req0 = 1'b0;
      req1 = 1'b1; op1 = 2'd0; data1 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         in_cycle();
         chk("clr_no_ce", reg_ce, 0);
         chk("clr_no_ack1", ack1, 0);
      end
      in_cycle();
      chk("pend_ce",    reg_ce, 1);
      chk("pend_ack1",  ack1,   1);
      chk("pend_reg_d", reg_d,  8'hFF);
      @(negedge CLK);
      req1 = 1'b0;
      @(negedge CLK);

      // Reserved op from req1
      req1 = 1'b1; op1 = 2'd3; data1 = 8'h3C;
      in_cycle();
      chk("rsv_ack1",  ack1,      1);
      chk("rsv_ce",    reg_ce,    0);
      chk("rsv_pre_b", reg_pre_b, 1);
      chk("rsv_clr_b", reg_clr_b, 1);
      chk("rsv_reg_d", reg_d,     8'hFF);
      @(negedge CLK);
      req1 = 1'b0;
      in_cycle();
      chk("rsv_no_recover", busy, 0);
      @(negedge CLK);

      // Both LOAD held together (last_grant is 1 here)
      req0 = 1'b1; op0 = 2'd0; data0 = 8'h11;
      req1 = 1'b1; op1 = 2'd0; data1 = 8'h22;
      for (int i = 0; i < 4; i++) begin
         in_cycle();
`ifdef DFF_BANK_SCHED_RR_EN
         chk("both_ack0", ack0, (i % 2 == 0) ? 1 : 0);
         chk("both_ack1", ack1, (i % 2 == 0) ? 0 : 1);
         chk("both_reg_d", reg_d, (i % 2 == 0) ? 8'h11 : 8'h22);
`else
         chk("both_ack0", ack0, 1);
         chk("both_ack1", ack1, 0);
         chk("both_reg_d", reg_d, 8'h11);
`endif
         if (i < 3) @(posedge CLK);
      end
      @(negedge CLK);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge CLK);

      // Reset in the middle of a SET's EXEC cycle
      req1 = 1'b1; op1 = 2'd1;
      in_cycle();
      chk("mid_pre_low", reg_pre_b, 0);
      #1 RST_b = 1'b0;
      #1;
      chk("mid_rst_pre_b", reg_pre_b,  1);
      chk("mid_rst_ack1",  ack1,       0);
      chk("mid_rst_busy",  busy,       0);
      chk("mid_rst_lg",    last_grant, 1);
      @(negedge CLK);
      req1  = 1'b0;
      RST_b = 1'b1;

      // Randomized traffic with occasional asynchronous resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         if ($urandom_range(0, 249) == 0) begin
            #2 RST_b = 1'b0;
            req0 = 1'b0; req1 = 1'b0;
            @(negedge CLK);
            RST_b = 1'b1;
         end else begin
            if (req0) begin
               if (ack0) begin
                  if ($urandom_range(0, 3) != 0) begin
                     req0 = 1'b0;
                  end else begin
                     op0 = 2'($urandom_range(0, 3)); data0 = 8'($urandom);
                  end
               end
            end else if ($urandom_range(0, 2) == 0) begin
               req0 = 1'b1; op0 = 2'($urandom_range(0, 3)); data0 = 8'($urandom);
            end
            if (req1) begin
               if (ack1) begin
                  if ($urandom_range(0, 3) != 0) begin
                     req1 = 1'b0;
                  end else begin
                     op1 = 2'($urandom_range(0, 3)); data1 = 8'($urandom);
                  end
               end
            end else if ($urandom_range(0, 2) == 0) begin
               req1 = 1'b1; op1 = 2'($urandom_range(0, 3)); data1 = 8'($urandom);
            end
         end
      end

      @(negedge CLK);
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

`default_nettype wire
